// File: rtl/sdram_arb_pkg.sv
// Shared widths and FSM state encoding for the SDRAM read-port arbiter.
package sdram_arb_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 128;

  typedef enum logic [2:0] {IDLE, ARB, WAIT_RDY, READ, STEP, FIN} arb_state_t;
endpackage

// File: rtl/sdram_read_arbiter_picker.sv
// Combinational winner selection: lowest urgent requester first, otherwise
// round-robin starting at rr_ptr.
module rr_priority_picker #(
  parameter int NREQ = 2,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  urgent,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);
  logic [NREQ-1:0]  hot;
  logic [IDX_W-1:0] k;
  logic             found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    k       = '0;
    hot     = req & urgent;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && hot[i]) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = IDX_W'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[k]) begin
        found   = 1'b1;
        win_idx = k;
      end
    end
    if (found) win[win_idx] = 1'b1;
    any = found;
  end
endmodule

// File: rtl/sdram_read_arbiter.sv
// Arbitrates NREQ burst readers onto one SDRAM read port, running each
// granted burst word by word and steering returned data to the owner.
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   Clk50,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        urgent,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   sdram_Wait,
  input  logic                   sdram_ac,
  input  logic [DATA_W-1:0]      sdram_data,
  output logic                   sdram_rd,
  output logic [ADDR_W-1:0]      sdram_addr
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TC_W  = $clog2(TIMEOUT + 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  own, rr_ptr, win_idx;
  logic [NREQ-1:0]   win;
  logic              any;
  logic [ADDR_W-1:0] cur, w_addr;
  logic [LEN_W-1:0]  len_r, cnt, w_len;
  logic [TC_W-1:0]   tcnt;

  rr_priority_picker #(.NREQ(NREQ)) u_picker (
    .req     (req),
    .urgent  (urgent),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign w_addr = req_addr[ADDR_W*win_idx +: ADDR_W];
  assign w_len  = req_len[LEN_W*win_idx +: LEN_W];
  assign busy   = (state != IDLE);

  always_ff @(posedge Clk50) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      rvalid      <= '0;
      done        <= '0;
      sdram_rd    <= 1'b0;
      sdram_addr  <= '0;
      rdata       <= '0;
      rr_ptr      <= '0;
      own         <= '0;
      cur         <= '0;
      len_r       <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      rvalid <= '0;
      done   <= '0;
      unique case (state)
        IDLE: if (|req) state <= ARB;
        ARB: begin
          if (any) begin
            grant <= win;
            own   <= win_idx;
            cur   <= w_addr;
            len_r <= w_len;
            cnt   <= '0;
            // zero-length bursts still complete with a done pulse
            if (w_len == '0) begin
              done  <= win;
              state <= FIN;
            end else begin
              state <= WAIT_RDY;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RDY: begin
          if (!sdram_Wait) begin
            sdram_rd   <= 1'b1;
            sdram_addr <= cur;
            tcnt       <= '0;
            state      <= READ;
          end
        end
        READ: begin
          if (sdram_ac) begin
            rdata    <= sdram_data;
            rvalid   <= grant;
            sdram_rd <= 1'b0;
            state    <= STEP;
          end else if (tcnt == TC_W'(TIMEOUT - 1)) begin
            sdram_rd    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= WAIT_RDY;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        STEP: begin
          cur <= cur + 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == len_r) begin
            done  <= grant;
            state <= FIN;
          end else if (!req[own]) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            state <= WAIT_RDY;
          end
        end
        FIN: begin
          grant  <= '0;
          rr_ptr <= (own == IDX_W'(NREQ - 1)) ? '0 : own + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter with a simple SDRAM responder model.
module tb_sdram_read_arbiter;
  import sdram_arb_pkg::*;
  localparam int NREQ = 2, LEN_W = 8, TIMEOUT = 16;

  logic                   Clk50 = 1'b0, reset_n = 1'b0;
  logic [NREQ-1:0]        req = '0, urgent = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*LEN_W-1:0]  req_len = '0;
  logic [NREQ-1:0]        grant, rvalid, done;
  logic [DATA_W-1:0]      rdata, sdram_data = '0;
  logic                   busy, timeout_err, sdram_rd;
  logic                   sdram_Wait = 1'b0, sdram_ac = 1'b0;
  logic [ADDR_W-1:0]      sdram_addr;

  int n_cmp = 0, n_bad = 0;
  int ac_delay = 2, rcnt = 0;
  bit ac_en = 1'b1, twohot = 1'b0;
  logic [NREQ-1:0]   auto_drop = '1, prev_gr = '0;
  logic              prev_rd = 1'b0;
  logic [ADDR_W-1:0] rd_addrs[$];
  logic [NREQ-1:0]   rv_q[$], done_q[$], gr_q[$];
  logic [DATA_W-1:0] rv_d[$];

  always #10 Clk50 = ~Clk50;

  sdram_read_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk50(Clk50), .reset_n(reset_n), .req(req), .urgent(urgent),
    .req_addr(req_addr), .req_len(req_len), .grant(grant), .rvalid(rvalid),
    .rdata(rdata), .done(done), .busy(busy), .timeout_err(timeout_err),
    .sdram_Wait(sdram_Wait), .sdram_ac(sdram_ac), .sdram_data(sdram_data),
    .sdram_rd(sdram_rd), .sdram_addr(sdram_addr)
  );

  function automatic logic [DATA_W-1:0] mkdata(input logic [ADDR_W-1:0] a);
    return {4{10'h2A5, a}};
  endfunction

  // One negedge step: log DUT activity, run the SDRAM model, let clients release req on done.
  task automatic tick();
    @(negedge Clk50);
    if (sdram_rd && !prev_rd) rd_addrs.push_back(sdram_addr);
    prev_rd = sdram_rd;
    if (rvalid != '0) begin rv_q.push_back(rvalid); rv_d.push_back(rdata); end
    if (done != '0) done_q.push_back(done);
    if (grant != '0 && prev_gr == '0) gr_q.push_back(grant);
    prev_gr = grant;
    if ($countones(grant) > 1) twohot = 1'b1;
    if (sdram_ac) begin
      sdram_ac = 1'b0;
      rcnt = 0;
    end else if (sdram_rd && ac_en) begin
      rcnt++;
      if (rcnt >= ac_delay) begin sdram_ac = 1'b1; sdram_data = mkdata(sdram_addr); end
    end else begin
      rcnt = 0;
    end
    req = req & ~(done & auto_drop);
  endtask

  task automatic clear_log();
    rd_addrs.delete(); rv_q.delete(); rv_d.delete(); done_q.delete(); gr_q.delete();
    twohot = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; urgent = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_len[i*LEN_W +: LEN_W]    = l;
  endtask

  task automatic wait_done(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (done_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({grant, rvalid, done, busy, sdram_rd, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0", {grant, rvalid, done, busy, sdram_rd, timeout_err});
    end
    n_cmp++;
    if (sdram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", sdram_addr); end
    n_cmp++;
    if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    clear_log();
    set_req(0, 22'h000100, 8'd4);
    req[0] = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 2'b00) begin n_bad++; $display("FAIL single_grant_early: got %b expected 00", grant); end
    tick();
    n_cmp++;
    if (grant !== 2'b01) begin n_bad++; $display("FAIL single_grant_t2: got %b expected 01", grant); end
    n_cmp++;
    if (sdram_rd !== 1'b0) begin n_bad++; $display("FAIL single_rd_t2: got %b expected 0", sdram_rd); end
    tick();
    n_cmp++;
    if (sdram_rd !== 1'b1) begin n_bad++; $display("FAIL single_rd_t3: got %b expected 1", sdram_rd); end
    wait_done(1, 100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_done_timeout: got 0 expected 1"); end
    repeat (3) tick();
    n_cmp++;
    if (rd_addrs.size() !== 4) begin n_bad++; $display("FAIL single_nrd: got %0d expected 4", rd_addrs.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_addrs[i] !== ADDR_W'(32'h100 + i)) begin
        n_bad++; $display("FAIL single_addr%0d: got %h expected %h", i, rd_addrs[i], 32'h100 + i);
      end
    end
    n_cmp++;
    if (rv_q.size() !== 4) begin n_bad++; $display("FAIL single_nrv: got %0d expected 4", rv_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rv_q[i] !== 2'b01 || rv_d[i] !== mkdata(ADDR_W'(32'h100 + i))) begin
        n_bad++; $display("FAIL single_rv%0d: got %b/%h expected 01/%h", i, rv_q[i], rv_d[i], mkdata(ADDR_W'(32'h100 + i)));
      end
    end
    n_cmp++;
    if (done_q.size() !== 1 || done_q[0] !== 2'b01) begin
      n_bad++; $display("FAIL single_done: got %0d pulses expected 1 on req0", done_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]   exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [ADDR_W-1:0] exp_a [6] = '{22'h10, 22'h11, 22'h20, 22'h21, 22'h10, 22'h11};
    do_reset();
    clear_log();
    set_req(0, 22'h000010, 8'd2);
    set_req(1, 22'h000020, 8'd2);
    auto_drop = 2'b10;
    req = 2'b11;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done_q.size() >= 3) begin req[0] = 1'b0; break; end
    end
    repeat (4) tick();
    auto_drop = '1;
    n_cmp++;
    if (gr_q.size() !== 3) begin n_bad++; $display("FAIL rr_ngrants: got %0d expected 3", gr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (gr_q[i] !== exp_g[i]) begin n_bad++; $display("FAIL rr_order%0d: got %b expected %b", i, gr_q[i], exp_g[i]); end
    end
    n_cmp++;
    if (twohot !== 1'b0) begin n_bad++; $display("FAIL rr_onehot: got two-hot grant expected one-hot"); end
    n_cmp++;
    if (rd_addrs.size() !== 6) begin n_bad++; $display("FAIL rr_nrd: got %0d expected 6", rd_addrs.size()); end
    else for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rd_addrs[i] !== exp_a[i]) begin n_bad++; $display("FAIL rr_addr%0d: got %h expected %h", i, rd_addrs[i], exp_a[i]); end
    end
  endtask

  task automatic test_urgent();
    bit ok;
    do_reset();
    clear_log();
    set_req(0, 22'h000030, 8'd1);
    set_req(1, 22'h000040, 8'd1);
    urgent = 2'b10;
    req = 2'b11;
    wait_done(2, 200, ok);
    n_cmp++;
    if (!ok || gr_q.size() !== 2 || gr_q[0] !== 2'b10 || gr_q[1] !== 2'b01) begin
      n_bad++; $display("FAIL urgent_one: got %0d grants first %b expected 2 first 10", gr_q.size(), gr_q[0]);
    end
    do_reset();
    clear_log();
    urgent = 2'b11;
    req = 2'b11;
    wait_done(2, 200, ok);
    n_cmp++;
    if (!ok || gr_q.size() !== 2 || gr_q[0] !== 2'b01 || gr_q[1] !== 2'b10) begin
      n_bad++; $display("FAIL urgent_both: got %0d grants first %b expected 2 first 01", gr_q.size(), gr_q[0]);
    end
    urgent = '0;
    repeat (3) tick();
  endtask

  task automatic test_wrap_and_zero();
    bit ok;
    logic [ADDR_W-1:0] exp_w [3] = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000};
    clear_log();
    set_req(0, 22'h3FFFFE, 8'd3);
    req[0] = 1'b1;
    wait_done(1, 100, ok);
    repeat (3) tick();
    n_cmp++;
    if (!ok || rd_addrs.size() !== 3) begin n_bad++; $display("FAIL wrap_nrd: got %0d expected 3", rd_addrs.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_addrs[i] !== exp_w[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h expected %h", i, rd_addrs[i], exp_w[i]); end
    end
    clear_log();
    set_req(0, 22'h000500, 8'd0);
    req[0] = 1'b1;
    tick();
    n_cmp++;
    if (done !== 2'b00) begin n_bad++; $display("FAIL zero_done_arb: got %b expected 00", done); end
    tick();
    n_cmp++;
    if (done !== 2'b01) begin n_bad++; $display("FAIL zero_done_fin: got %b expected 01", done); end
    repeat (3) tick();
    n_cmp++;
    if (rd_addrs.size() !== 0 || done_q.size() !== 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_norw: got rd %0d done %0d busy %b expected 0 1 0", rd_addrs.size(), done_q.size(), busy);
    end
  endtask

  task automatic test_wait();
    bit ok;
    clear_log();
    sdram_Wait = 1'b1;
    set_req(0, 22'h000600, 8'd1);
    req[0] = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (sdram_rd !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL wait_hold: got rd %b busy %b expected 0 1", sdram_rd, busy);
    end
    sdram_Wait = 1'b0;
    tick();
    n_cmp++;
    if (sdram_rd !== 1'b1) begin n_bad++; $display("FAIL wait_release: got %b expected 1", sdram_rd); end
    sdram_Wait = 1'b1;
    tick();
    n_cmp++;
    if (sdram_rd !== 1'b1) begin n_bad++; $display("FAIL wait_in_read: got %b expected 1", sdram_rd); end
    sdram_Wait = 1'b0;
    wait_done(1, 50, ok);
    n_cmp++;
    if (!ok || rv_d.size() !== 1 || rv_d[0] !== mkdata(22'h000600)) begin
      n_bad++; $display("FAIL wait_data: got %0d words expected 1 with %h", rv_d.size(), mkdata(22'h000600));
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    bit ok, ok2;
    int hi, lo;
    clear_log();
    ac_en = 1'b0;
    set_req(0, 22'h000200, 8'd2);
    req[0] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (sdram_rd) begin ok = 1'b1; break; end
    end
    hi = 0;
    while (sdram_rd && hi < 100) begin hi++; tick(); end
    lo = 0;
    ac_en = 1'b1;
    while (!sdram_rd && lo < 100) begin lo++; tick(); end
    n_cmp++;
    if (!ok || hi != TIMEOUT) begin n_bad++; $display("FAIL tmo_rd_high: got %0d cycles expected %0d", hi, TIMEOUT); end
    n_cmp++;
    if (lo != 1) begin n_bad++; $display("FAIL tmo_rd_gap: got %0d cycles expected 1", lo); end
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b expected 1", timeout_err); end
    wait_done(1, 100, ok2);
    repeat (3) tick();
    n_cmp++;
    if (!ok2 || rd_addrs.size() !== 3 || rd_addrs[0] !== 22'h200 || rd_addrs[1] !== 22'h200 || rd_addrs[2] !== 22'h201) begin
      n_bad++; $display("FAIL tmo_retry: got %0d reads expected 200,200,201", rd_addrs.size());
    end
    n_cmp++;
    if (rv_q.size() !== 2 || timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_words: got %0d words err %b expected 2 1", rv_q.size(), timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    set_req(0, 22'h000300, 8'd5);
    req[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (rv_q.size() >= 1 && sdram_rd) break;
    end
    reset_n = 1'b0;
    req = '0;
    tick();
    n_cmp++;
    if ({grant, rvalid, done, busy, sdram_rd, timeout_err} !== '0 || sdram_addr !== '0 || rdata !== '0) begin
      n_bad++; $display("FAIL midreset: got ctl %b addr %h expected all 0",
                        {grant, rvalid, done, busy, sdram_rd, timeout_err}, sdram_addr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    clear_log();
    set_req(0, 22'h000400, 8'd5);
    req[0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rv_q.size() >= 2) begin req[0] = 1'b0; break; end
    end
    repeat (6) tick();
    n_cmp++;
    if (done_q.size() !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses expected 0", done_q.size()); end
    n_cmp++;
    if (rv_q.size() !== 2 || rd_addrs.size() !== 2) begin
      n_bad++; $display("FAIL abort_words: got %0d/%0d expected 2/2", rv_q.size(), rd_addrs.size());
    end
    n_cmp++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got grant %b busy %b expected 00 0", grant, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_urgent();
    test_wrap_and_zero();
    test_wait();
    test_timeout();
    test_reset_mid();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
